// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from last_idx+1, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

  logic [IDX_W-1:0] k;

  // First set request after the previous winner takes the grant.
  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    valid      = 1'b0;
    k          = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = IDX_W'((int'(last_idx) + i) % NUM_REQ);
      if (!valid && req[k]) begin
        valid         = 1'b1;
        winner_oh[k]  = 1'b1;
        winner_idx    = k;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-granular arbiter in front of the 8-entry FIFO write port.
//
// state | meaning
// IDLE  | no grant; waiting for a request with enough FIFO space
// GRANT | one producer owns the write port until last, burst cap or abandon
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int MIN_SPACE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        last,
  input  logic [DATA_W*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data,
  input  logic                      fifo_full,
  input  logic [CNT_W-1:0]          fifo_words
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // Highest occupancy that still leaves MIN_SPACE free entries.
  localparam logic [CNT_W:0]   WORDS_LIMIT = (CNT_W+1)'(FIFO_DEPTH - MIN_SPACE);
  localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(MAX_BURST - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   burst_q, burst_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               space_ok;
  logic               req_g;
  logic               last_g;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .last_idx   (ptr_q),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  assign space_ok = ({1'b0, fifo_words} <= WORDS_LIMIT);
  // gnt_q is one-hot, so masking and OR-reducing selects the granted lane.
  assign req_g    = |(req & gnt_q);
  assign last_g   = |(last & gnt_q);

  // Acknowledge the granted lane whenever the FIFO can take a word.
  always_comb begin
    ack = '0;
    if (state_q == GRANT) begin
      ack = gnt_q & req & {NUM_REQ{~fifo_full}};
    end
  end

  assign fifo_wr_en = |ack;

  // Steer the granted lane to the FIFO; zero when nobody holds the grant.
  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        fifo_data = data[DATA_W*i +: DATA_W];
      end
    end
  end

  // FSM next-state: issue grants in IDLE, release on last, burst cap or abandon.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (pick_valid && !fifo_full && space_ok) begin
          state_d = GRANT;
          gnt_d   = pick_oh;
          busy_d  = 1'b1;
          ptr_d   = pick_idx;
          burst_d = '0;
        end
      end
      GRANT: begin
        if (!req_g) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (fifo_wr_en) begin
          burst_d = burst_q + 1'b1;
          if (last_g || (burst_q == BURST_LAST)) begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; pointer resets to the top index so lane 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule
